// File: rtl/adder_arbiter_if.sv
// Bundle of requester operand channels and the shared result channel for adder_arbiter.
// slave is the arbiter side, master is the requester/consumer side.
interface adder_arbiter_if #(
  parameter int WIDTH = 32
);
  logic [2:0]         req_valid;
  logic [3*WIDTH-1:0] req_a;
  logic [3*WIDTH-1:0] req_b;
  logic [2:0]         req_ready;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_sum;
  logic [1:0]         res_id;
  logic               res_ovf;
  logic [15:0]        txn_count;

  modport slave (
    input  req_valid, req_a, req_b, res_ready,
    output req_ready, res_valid, res_sum, res_id, res_ovf, txn_count
  );

  modport master (
    output req_valid, req_a, req_b, res_ready,
    input  req_ready, res_valid, res_sum, res_id, res_ovf, txn_count
  );
endinterface

// File: rtl/adder_arbiter.sv
// Three requesters share one signed adder through a single-entry result register.
// Round-robin grant starts its search at ptr, which moves past each winner.
module adder_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  adder_arbiter_if.slave  bus
);
  localparam int N = 3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [1:0]       id_q, id_d;
  logic             ovf_q, ovf_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [WIDTH-1:0] op_a [N];
  logic [WIDTH-1:0] op_b [N];
  logic [1:0]       cand_idx [N];
  logic [N-1:0]     cand_vld;

  logic             accept;
  logic             any_valid;
  logic [1:0]       grant_idx;
  logic             xfer;
  logic [N-1:0]     grant_vec;
  logic [WIDTH-1:0] a_sel, b_sel, sum_raw;
  logic             ovf_raw;

  // (p + k) mod 3 for p, k in 0..2
  function automatic logic [1:0] wrap_add(input logic [1:0] p, input logic [1:0] k);
    logic [2:0] s;
    s = {1'b0, p} + {1'b0, k};
    if (s >= 3'd3) s = s - 3'd3;
    return s[1:0];
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign op_a[gi]     = bus.req_a[gi*WIDTH +: WIDTH];
      assign op_b[gi]     = bus.req_b[gi*WIDTH +: WIDTH];
      assign cand_idx[gi] = wrap_add(ptr_q, 2'(gi));
      assign cand_vld[gi] = bus.req_valid[cand_idx[gi]];
    end
  endgenerate

  assign accept = (state_q == ST_EMPTY) || bus.res_ready;

  // Lowest rotated offset wins; scanning downward leaves it as the final pick.
  always_comb begin
    grant_idx = cand_idx[0];
    any_valid = 1'b0;
    for (int k = N-1; k >= 0; k--) begin
      if (cand_vld[k]) begin
        grant_idx = cand_idx[k];
        any_valid = 1'b1;
      end
    end
  end

  assign xfer      = accept && any_valid;
  assign grant_vec = (xfer && rst_n) ? (3'b001 << grant_idx) : 3'b000;

  // Single shared adder fed by the granted requester's operands.
  assign a_sel   = op_a[grant_idx];
  assign b_sel   = op_b[grant_idx];
  assign sum_raw = a_sel + b_sel;
  assign ovf_raw = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) && (sum_raw[WIDTH-1] != a_sel[WIDTH-1]);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sum_d   = sum_q;
    id_d    = id_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    if (xfer) begin
      state_d = ST_FULL;
      ptr_d   = wrap_add(grant_idx, 2'd1);
      sum_d   = sum_raw;
      id_d    = grant_idx;
      ovf_d   = ovf_raw;
      cnt_d   = cnt_q + 16'd1;
    end else if (state_q == ST_FULL && bus.res_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      ptr_q   <= 2'd0;
      sum_q   <= '0;
      id_q    <= 2'd0;
      ovf_q   <= 1'b0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sum_q   <= sum_d;
      id_q    <= id_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.req_ready = grant_vec;
  assign bus.res_valid = (state_q == ST_FULL);
  assign bus.res_sum   = sum_q;
  assign bus.res_id    = id_q;
  assign bus.res_ovf   = ovf_q;
  assign bus.txn_count = cnt_q;
endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter: a reference arbiter model predicts grants,
// and expected results queue up at grant time and are popped when the result register loads.
module tb_adder_arbiter;
    localparam int W = 32;

    typedef struct packed {
        logic [W-1:0] sum;
        logic [1:0]   id;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests = 0;
    int   fails = 0;

    exp_t exp_q[$];
    exp_t m_last;
    int   m_ptr;
    bit   m_valid;
    logic [15:0] m_cnt;
    bit   quiet;

    adder_arbiter_if #(.WIDTH(W)) bus ();

    adder_arbiter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input bit ok, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.req_a[i*W +: W] = a;
        bus.req_b[i*W +: W] = b;
    endtask

    task automatic model_reset();
        m_ptr   = 0;
        m_valid = 1'b0;
        m_cnt   = 16'd0;
        exp_q.delete();
    endtask

    task automatic cycle(input string tag);
        logic [2:0]   eg;
        int           g;
        int           idx;
        logic [W-1:0] a, b, s;
        exp_t         e;
        @(negedge clk);
        eg = 3'b000;
        g  = -1;
        if (!m_valid || bus.res_ready) begin
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr + k) % 3;
                if (g < 0 && bus.req_valid[idx]) g = idx;
            end
        end
        if (g >= 0) eg[g] = 1'b1;
        chk({tag, ".ready"}, bus.req_ready === eg, W'(bus.req_ready), W'(eg));
        if (g >= 0) begin
            a = bus.req_a[g*W +: W];
            b = bus.req_b[g*W +: W];
            s = a + b;
            e.sum = s;
            e.id  = 2'(g);
            e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            exp_q.push_back(e);
            m_ptr   = (g + 1) % 3;
            m_cnt   = m_cnt + 16'd1;
            m_valid = 1'b1;
        end else if (bus.res_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
        chk({tag, ".valid"}, bus.res_valid === m_valid, W'(bus.res_valid), W'(m_valid));
        chk({tag, ".count"}, bus.txn_count === m_cnt, W'(bus.txn_count), W'(m_cnt));
        if (g >= 0) begin
            e = exp_q.pop_front();
            chk({tag, ".sum"}, bus.res_sum === e.sum, bus.res_sum, e.sum);
            chk({tag, ".id"}, bus.res_id === e.id, W'(bus.res_id), W'(e.id));
            chk({tag, ".ovf"}, bus.res_ovf === e.ovf, W'(bus.res_ovf), W'(e.ovf));
            m_last = e;
        end else if (m_valid) begin
            chk({tag, ".hold_sum"}, bus.res_sum === m_last.sum, bus.res_sum, m_last.sum);
            chk({tag, ".hold_id"}, bus.res_id === m_last.id, W'(bus.res_id), W'(m_last.id));
            chk({tag, ".hold_ovf"}, bus.res_ovf === m_last.ovf, W'(bus.res_ovf), W'(m_last.ovf));
        end
        if (!quiet)
            $display("[TB] %s grant=%0d valid=%0b sum=%0h id=%0d ovf=%0b count=%0h",
                     tag, g, bus.res_valid, bus.res_sum, bus.res_id, bus.res_ovf, bus.txn_count);
    endtask

    initial begin
        quiet = 1'b0;
        model_reset();
        m_last = '0;
        bus.req_valid = 3'b111;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b1;
        rst_n = 1'b0;

        #12;
        chk("rst.valid", bus.res_valid === 1'b0, W'(bus.res_valid), 0);
        chk("rst.sum", bus.res_sum === 32'h0, bus.res_sum, 0);
        chk("rst.id", bus.res_id === 2'd0, W'(bus.res_id), 0);
        chk("rst.ovf", bus.res_ovf === 1'b0, W'(bus.res_ovf), 0);
        chk("rst.count", bus.txn_count === 16'h0, W'(bus.txn_count), 0);
        chk("rst.ready", bus.req_ready === 3'b000, W'(bus.req_ready), 0);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.req_valid = 3'b000;
        @(posedge clk);
        #1;

        set_req(0, 32'hFFFF_FFFB, 32'hFFFF_FFF9);
        bus.req_valid = 3'b001;
        cycle("r033");
        chk("r033.lit_sum", bus.res_sum === 32'hFFFF_FFF4, bus.res_sum, 32'hFFFF_FFF4);
        chk("r033.lit_cnt", bus.txn_count === 16'd1, W'(bus.txn_count), 1);

        set_req(1, 32'h7FFF_FFFF, 32'h0000_0001);
        bus.req_valid = 3'b010;
        cycle("r034a");
        chk("r034a.lit_sum", bus.res_sum === 32'h8000_0000, bus.res_sum, 32'h8000_0000);
        chk("r034a.lit_ovf", bus.res_ovf === 1'b1, W'(bus.res_ovf), 1);
        set_req(2, 32'h8000_0000, 32'h8000_0000);
        bus.req_valid = 3'b100;
        cycle("r034b");
        chk("r034b.lit_sum", bus.res_sum === 32'h0, bus.res_sum, 0);
        chk("r034b.lit_ovf", bus.res_ovf === 1'b1, W'(bus.res_ovf), 1);

        set_req(0, 32'd10, 32'd1);
        set_req(1, 32'd20, 32'd2);
        set_req(2, 32'd30, 32'd3);
        bus.req_valid = 3'b111;
        for (int k = 0; k < 6; k++) begin
            cycle("r035");
            chk("r035.lit_id", bus.res_id === 2'(k % 3), W'(bus.res_id), W'(k % 3));
        end

        bus.res_ready = 1'b0;
        bus.req_valid = 3'b010;
        for (int k = 0; k < 4; k++) begin
            set_req(1, 32'(100 + k), 32'(k));
            cycle("r036.stall");
        end
        bus.res_ready = 1'b1;
        cycle("r036.go");
        chk("r036.lit_id", bus.res_id === 2'd1, W'(bus.res_id), 1);
        chk("r036.lit_sum", bus.res_sum === 32'd106, bus.res_sum, 106);

        bus.req_valid = 3'b000;
        cycle("drain");
        bus.res_ready = 1'b0;
        set_req(0, 32'd5, 32'd6);
        bus.req_valid = 3'b001;
        cycle("load");
        bus.req_valid = 3'b111;

        #2;
        rst_n = 1'b0;
        #1;
        chk("r037.valid", bus.res_valid === 1'b0, W'(bus.res_valid), 0);
        chk("r037.sum", bus.res_sum === 32'h0, bus.res_sum, 0);
        chk("r037.id", bus.res_id === 2'd0, W'(bus.res_id), 0);
        chk("r037.ovf", bus.res_ovf === 1'b0, W'(bus.res_ovf), 0);
        chk("r037.count", bus.txn_count === 16'h0, W'(bus.txn_count), 0);
        chk("r037.ready", bus.req_ready === 3'b000, W'(bus.req_ready), 0);
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        bus.res_ready = 1'b1;
        bus.req_valid = 3'b000;
        cycle("r032.idle");
        bus.req_valid = 3'b111;
        cycle("r037.first");
        chk("r037.lit_id", bus.res_id === 2'd0, W'(bus.res_id), 0);

        quiet = 1'b1;
        for (int k = 1; k < 32'h10000; k++) begin
            set_req(k % 3, 32'($urandom), 32'($urandom));
            cycle("r038");
        end
        quiet = 1'b0;
        chk("r038.wrap", bus.txn_count === 16'h0000, W'(bus.txn_count), 0);
        $display("[TB] r038 count after 0x10000 transfers=%0h", bus.txn_count);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter: WIDTH, 32, operand/result width in bits.
REQ-002 SHALL have port: clk  input  1  sole clock, rising-edge active.
REQ-003 SHALL have port: rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: req_valid  input  3  per-requester operand valid; bit i = requester i.
REQ-005 SHALL have port: req_a  input  3*WIDTH  signed operand A; requester i at bits [i*WIDTH +: WIDTH].
REQ-006 SHALL have port: req_b  input  3*WIDTH  signed operand B; same packing as req_a.
REQ-007 SHALL have port: req_ready  output  3  grant; one-hot or zero.
REQ-008 SHALL have port: res_valid  output  1  result register holds a valid sum.
REQ-009 SHALL have port: res_ready  input  1  consumer accepts the result.
REQ-010 SHALL have port: res_sum  output  WIDTH  signed sum of granted operands.
REQ-011 SHALL have port: res_id  output  2  index (0..2) of the requester that produced res_sum.
REQ-012 SHALL have port: res_ovf  output  1  signed overflow of res_sum.
REQ-013 SHALL have port: txn_count  output  16  count of completed requester transfers.

Function
REQ-014 The block SHALL share one WIDTH-bit adder among 3 requesters through a single-entry output register.
REQ-015 The internal signal accept = !res_valid || res_ready SHALL gate all grants; when accept = 0, req_ready SHALL be 3'b000.
REQ-016 When accept = 1, req_ready SHALL be combinational and one-hot: the first set bit of req_valid, searching ptr, ptr+1, ptr+2 (mod 3).
REQ-017 req_ready[i] SHALL never assert while req_valid[i] = 0.
REQ-018 A transfer SHALL occur on a rising edge where req_valid[i] && req_ready[i].
REQ-019 On a transfer: res_sum <= a_i + b_i mod 2^WIDTH; res_id <= i; res_valid <= 1.
REQ-020 On a transfer, res_ovf SHALL be set when a_i and b_i have equal sign bits and the sum's sign bit differs; otherwise it SHALL be 0.
REQ-021 Latency from transfer edge to res_valid = 1 SHALL be exactly 1 cycle.
REQ-022 On a transfer, ptr SHALL become (i+1) mod 3; with no transfer, ptr SHALL hold.
REQ-023 While res_valid && !res_ready, res_sum, res_id and res_ovf SHALL hold stable.
REQ-024 Simultaneous res_ready handshake and new transfer in the same edge SHALL load the new result (full throughput: 1 result per cycle).
REQ-025 After a res_ready handshake with no new transfer, res_valid SHALL clear on that edge.
REQ-026 txn_count SHALL increment by 1 per transfer and wrap from 0xFFFF to 0x0000.
REQ-027 Requesters SHALL hold req_valid and operands until granted; the block SHALL tolerate, without error, changes made before a grant.
REQ-028 The two-state output FSM SHALL be EMPTY (res_valid = 0) and FULL (res_valid = 1):
- EMPTY -> FULL on a transfer.
- FULL -> EMPTY on res_ready with no transfer.
- FULL -> FULL otherwise.

Reset
REQ-029 While rst_n = 0, the following SHALL take these values immediately, independent of clk: res_valid = 0, res_sum = 0, res_id = 0, res_ovf = 0, txn_count = 0, ptr = 0.
REQ-030 While rst_n = 0, req_ready SHALL be 3'b000.
REQ-031 The first grant after rst_n deasserts SHALL favour requester 0.
REQ-032 Reset asserted with res_valid = 1 SHALL discard the held result; no result SHALL appear after release without a new transfer.

Verification
REQ-033 Only req 0 valid, a = -5, b = -7, res_ready = 1 -> next cycle: res_valid = 1, res_sum = -12, res_id = 0, res_ovf = 0, txn_count = 1.
REQ-034 req 1: a = 0x7FFFFFFF, b = 1 -> res_sum = 0x80000000, res_ovf = 1. req 2: a = 0x80000000, b = 0x80000000 -> res_sum = 0, res_ovf = 1.
REQ-035 All 3 requesters valid continuously after reset, res_ready = 1 -> grants 0, 1, 2, 0, ... on consecutive cycles; res_id follows the same sequence 1 cycle later.
REQ-036 res_valid = 1, res_ready = 0 for 4 cycles with req 1 valid -> req_ready = 0 and outputs stable throughout; raising res_ready grants req 1 on the same cycle.
REQ-037 rst_n pulsed low mid-stream while res_valid = 1 -> all outputs 0 asynchronously; after release, a grant to req 0 with 3 valid requesters.
REQ-038 0x10000 transfers -> txn_count wraps to 0x0000.
